// File: rtl/rv32_insn_pkg.sv
// Shared RV32I definitions for the fetch/latch stage.
//   - 7-bit base opcodes used by the classifier.
//   - Fetch FSM state encoding (S_IDLE, S_FETCH, S_HOLD).
//   - Packed bundle of the latched class/abort flags.
package rv32_insn_pkg;

   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic rinsn;
      logic iinsn;
      logic load;
      logic store;
      logic branch;
      logic illegal;
      logic misalign;
      logic timeout;
   } insn_flags_t;

endpackage

// File: rtl/rv32_insn_classify.sv
// Combinational RV32I opcode classifier.
// Ports:
//   insn_i     32-bit instruction word
//   rinsn_o    OP (R-type)
//   iinsn_o    OP-IMM
//   load_o     LOAD
//   store_o    STORE
//   branch_o   BRANCH
//   illegal_o  not a legal RV32I base opcode; all class flags 0 when set
// Only the opcode field is inspected; funct3/funct7 are not checked.
module rv32_insn_classify
   import rv32_insn_pkg::*;
(
   input  logic [31:0] insn_i,
   output logic        rinsn_o,
   output logic        iinsn_o,
   output logic        load_o,
   output logic        store_o,
   output logic        branch_o,
   output logic        illegal_o
);

   // Upper bits carry operands/functs that this classifier ignores.
   logic unused_upper;
   assign unused_upper = ^insn_i[31:7];

   always_comb begin
      rinsn_o   = 1'b0;
      iinsn_o   = 1'b0;
      load_o    = 1'b0;
      store_o   = 1'b0;
      branch_o  = 1'b0;
      illegal_o = 1'b0;
      if (insn_i[1:0] != 2'b11) begin
         illegal_o = 1'b1;
      end else begin
         case (insn_i[6:0])
            OPC_OP:     rinsn_o  = 1'b1;
            OPC_OPIMM:  iinsn_o  = 1'b1;
            OPC_LOAD:   load_o   = 1'b1;
            OPC_STORE:  store_o  = 1'b1;
            OPC_BRANCH: branch_o = 1'b1;
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_MISCMEM, OPC_SYSTEM: ;
            default:    illegal_o = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/insn_fetch_latch.sv
// Instruction fetch-and-latch stage: accepts a fetch request, runs one
// valid/ready memory read, latches the word plus class flags and holds them
// until the consumer acknowledges. Misaligned fetches and (optionally) a
// memory that never answers are reported as aborted fetches.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   fetch_req/fetch_addr/fetch_ready  request side (accept = req & ready)
//   mem_valid/mem_addr/mem_rdata/mem_ready  memory read port
//   insn_valid/insn_ack             latched-output handshake
//   latched_*                       captured word and one-hot flags
//   state_o                         current FSM state (debug)
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; valid and its payload stay constant until that edge.
module insn_fetch_latch
   import rv32_insn_pkg::*;
#(
   parameter bit CATCH_MISALIGN = 1'b1,
   parameter int WAIT_TIMEOUT   = 0,
   parameter int TIMEOUT_W      = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_req,
   input  logic [31:0] fetch_addr,
   output logic        fetch_ready,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        insn_valid,
   input  logic        insn_ack,
   output logic [31:0] latched_insn,
   output logic        latched_rinsn,
   output logic        latched_iinsn,
   output logic        latched_load,
   output logic        latched_store,
   output logic        latched_branch,
   output logic        latched_illegal,
   output logic        latched_misalign,
   output logic        latched_timeout,
   output logic [1:0]  state_o
);

   localparam logic [TIMEOUT_W-1:0] TO_LAST =
      (WAIT_TIMEOUT > 0) ? TIMEOUT_W'(WAIT_TIMEOUT - 1) : '0;

   fetch_state_e         state_q, state_d;
   logic [31:0]          mem_addr_q, mem_addr_d;
   logic [31:0]          insn_q, insn_d;
   insn_flags_t          flags_q, flags_d;
   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

   insn_flags_t rd_flags;
   logic        accept;
   logic        misaligned;

   rv32_insn_classify u_classify (
      .insn_i    (mem_rdata),
      .rinsn_o   (rd_flags.rinsn),
      .iinsn_o   (rd_flags.iinsn),
      .load_o    (rd_flags.load),
      .store_o   (rd_flags.store),
      .branch_o  (rd_flags.branch),
      .illegal_o (rd_flags.illegal)
   );
   assign rd_flags.misalign = 1'b0;
   assign rd_flags.timeout  = 1'b0;

   assign fetch_ready = (state_q == S_IDLE) | ((state_q == S_HOLD) & insn_ack);
   assign accept      = fetch_req & fetch_ready;
   assign misaligned  = CATCH_MISALIGN && (fetch_addr[1:0] != 2'b00);

   always_comb begin
      state_d    = state_q;
      mem_addr_d = mem_addr_q;
      insn_d     = insn_q;
      flags_d    = flags_q;
      cnt_d      = cnt_q;
      case (state_q)
         S_IDLE, S_HOLD: begin
            // An ack in HOLD that coincides with a new accept skips IDLE.
            if (accept) begin
               mem_addr_d = {fetch_addr[31:2], 2'b00};
               if (misaligned) begin
                  state_d  = S_HOLD;
                  insn_d   = '0;
                  flags_d  = '0;
                  flags_d.misalign = 1'b1;
               end else begin
                  state_d = S_FETCH;
                  cnt_d   = '0;
               end
            end else if (state_q == S_HOLD && insn_ack) begin
               state_d = S_IDLE;
            end
         end
         S_FETCH: begin
            // mem_ready in the expiry cycle takes priority over the timeout.
            if (mem_ready) begin
               state_d = S_HOLD;
               insn_d  = mem_rdata;
               flags_d = rd_flags;
            end else if (WAIT_TIMEOUT > 0) begin
               if (cnt_q == TO_LAST) begin
                  state_d = S_HOLD;
                  insn_d  = '0;
                  flags_d = '0;
                  flags_d.timeout = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         mem_addr_q <= '0;
         insn_q     <= '0;
         flags_q    <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         mem_addr_q <= mem_addr_d;
         insn_q     <= insn_d;
         flags_q    <= flags_d;
         cnt_q      <= cnt_d;
      end
   end

   assign mem_valid        = (state_q == S_FETCH);
   assign mem_addr         = mem_addr_q;
   assign insn_valid       = (state_q == S_HOLD);
   assign latched_insn     = insn_q;
   assign latched_rinsn    = flags_q.rinsn;
   assign latched_iinsn    = flags_q.iinsn;
   assign latched_load     = flags_q.load;
   assign latched_store    = flags_q.store;
   assign latched_branch   = flags_q.branch;
   assign latched_illegal  = flags_q.illegal;
   assign latched_misalign = flags_q.misalign;
   assign latched_timeout  = flags_q.timeout;
   assign state_o          = state_q;

endmodule

// File: tb/tb_insn_fetch_latch.sv
module tb_insn_fetch_latch;

   // Flag vector order: {rinsn, iinsn, load, store, branch, illegal, misalign, timeout}
   localparam logic [7:0] F_NONE  = 8'h00;
   localparam logic [7:0] F_R     = 8'h80;
   localparam logic [7:0] F_I     = 8'h40;
   localparam logic [7:0] F_LOAD  = 8'h20;
   localparam logic [7:0] F_STORE = 8'h10;
   localparam logic [7:0] F_BR    = 8'h08;
   localparam logic [7:0] F_ILL   = 8'h04;
   localparam logic [7:0] F_MIS   = 8'h02;
   localparam logic [7:0] F_TO    = 8'h01;

   int total = 0;
   int bad   = 0;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fetch_req = 1'b0;
   logic [31:0] fetch_addr = '0;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;
   logic        insn_ack = 1'b0;

   // ---- clock/reset block ----
   always #5 clk = ~clk;

   // default-parameter instance
   logic        fetch_ready, mem_valid, insn_valid;
   logic [31:0] mem_addr, latched_insn;
   logic        l_r, l_i, l_ld, l_st, l_br, l_il, l_mis, l_to;
   logic [1:0]  state;
   logic [7:0]  flags;
   assign flags = {l_r, l_i, l_ld, l_st, l_br, l_il, l_mis, l_to};

   insn_fetch_latch dut (
      .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_ready(fetch_ready), .mem_valid(mem_valid), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .insn_valid(insn_valid),
      .insn_ack(insn_ack), .latched_insn(latched_insn), .latched_rinsn(l_r),
      .latched_iinsn(l_i), .latched_load(l_ld), .latched_store(l_st),
      .latched_branch(l_br), .latched_illegal(l_il), .latched_misalign(l_mis),
      .latched_timeout(l_to), .state_o(state)
   );

   // timeout instance, shares inputs
   logic        t_fetch_ready, t_mem_valid, t_insn_valid;
   logic [31:0] t_mem_addr, t_latched_insn;
   logic        t_r, t_i, t_ld, t_st, t_br, t_il, t_mis, t_to;
   logic [1:0]  t_state;
   logic [7:0]  t_flags;
   assign t_flags = {t_r, t_i, t_ld, t_st, t_br, t_il, t_mis, t_to};

   insn_fetch_latch #(.CATCH_MISALIGN(1'b1), .WAIT_TIMEOUT(4), .TIMEOUT_W(8)) dut_t (
      .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_ready(t_fetch_ready), .mem_valid(t_mem_valid), .mem_addr(t_mem_addr),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .insn_valid(t_insn_valid),
      .insn_ack(insn_ack), .latched_insn(t_latched_insn), .latched_rinsn(t_r),
      .latched_iinsn(t_i), .latched_load(t_ld), .latched_store(t_st),
      .latched_branch(t_br), .latched_illegal(t_il), .latched_misalign(t_mis),
      .latched_timeout(t_to), .state_o(t_state)
   );

   // ---- driver tasks ----
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      fetch_req = 1'b0; mem_ready = 1'b0; insn_ack = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   // Presents a request and lets the accepting edge pass.
   task automatic issue(input logic [31:0] addr);
      fetch_req = 1'b1; fetch_addr = addr;
      tick();
      fetch_req = 1'b0;
   endtask

   task automatic release_hold();
      insn_ack = 1'b1;
      tick();
      insn_ack = 1'b0;
   endtask

   // ---- scenarios ----
   task automatic test_reset();
      do_reset();
      total++;
      if ({mem_valid, insn_valid, fetch_ready} !== 3'b001 || mem_addr !== 32'h0 ||
          latched_insn !== 32'h0 || flags !== F_NONE || state !== 2'd0) begin
         bad++;
         $display("FAIL reset: mv=%b iv=%b fr=%b addr=%h insn=%h flags=%h st=%0d, want 0 0 1 0 0 00 0",
                  mem_valid, insn_valid, fetch_ready, mem_addr, latched_insn, flags, state);
      end
   endtask

   task automatic test_add_min_latency();
      issue(32'h100);
      total++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h100 || insn_valid !== 1'b0) begin
         bad++;
         $display("FAIL add_fetch: mv=%b addr=%h iv=%b, want 1 00000100 0", mem_valid, mem_addr, insn_valid);
      end
      mem_ready = 1'b1; mem_rdata = 32'h00B50533;
      tick();
      mem_ready = 1'b0;
      total++;
      if (insn_valid !== 1'b1 || mem_valid !== 1'b0 || latched_insn !== 32'h00B50533 || flags !== F_R) begin
         bad++;
         $display("FAIL add_latch: iv=%b mv=%b insn=%h flags=%h, want 1 0 00b50533 %h",
                  insn_valid, mem_valid, latched_insn, flags, F_R);
      end
      release_hold();
      total++;
      if (insn_valid !== 1'b0 || latched_insn !== 32'h00B50533 || flags !== F_R || fetch_ready !== 1'b1) begin
         bad++;
         $display("FAIL add_release: iv=%b insn=%h flags=%h fr=%b, want 0 00b50533 %h 1",
                  insn_valid, latched_insn, flags, fetch_ready, F_R);
      end
   endtask

   task automatic test_addi_wait_hold();
      int errs = 0;
      issue(32'h204);
      for (int i = 0; i < 5; i++) begin
         if (mem_valid !== 1'b1 || mem_addr !== 32'h204 || insn_valid !== 1'b0) errs++;
         mem_rdata = 32'hDEAD0000 + i; // not ready, data is noise
         tick();
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL addi_wait: %0d cycles with mv/addr/iv != 1/00000204/0", errs);
      end
      mem_ready = 1'b1; mem_rdata = 32'h00A00093;
      tick();
      mem_ready = 1'b0; mem_rdata = 32'hFFFFFFFF;
      errs = 0;
      for (int i = 0; i < 4; i++) begin
         if (insn_valid !== 1'b1 || latched_insn !== 32'h00A00093 || flags !== F_I) errs++;
         tick();
      end
      total++;
      if (errs != 0 || insn_valid !== 1'b1 || flags !== F_I) begin
         bad++;
         $display("FAIL addi_hold: %0d unstable cycles, iv=%b flags=%h, want 0 1 %h", errs, insn_valid, flags, F_I);
      end
   endtask

   // Entered in HOLD from the previous scenario.
   task automatic test_back_to_back();
      insn_ack = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h208;
      #1;
      total++;
      if (fetch_ready !== 1'b1) begin
         bad++;
         $display("FAIL b2b_ready: fetch_ready=%b, want 1", fetch_ready);
      end
      tick();
      insn_ack = 1'b0; fetch_req = 1'b0;
      total++;
      if (mem_valid !== 1'b1 || insn_valid !== 1'b0 || mem_addr !== 32'h208 || state !== 2'd1) begin
         bad++;
         $display("FAIL b2b_fetch: mv=%b iv=%b addr=%h st=%0d, want 1 0 00000208 1", mem_valid, insn_valid, mem_addr, state);
      end
      mem_ready = 1'b1; mem_rdata = 32'h0000A103;
      tick();
      mem_ready = 1'b0;
      total++;
      if (insn_valid !== 1'b1 || latched_insn !== 32'h0000A103 || flags !== F_LOAD) begin
         bad++;
         $display("FAIL b2b_load: iv=%b insn=%h flags=%h, want 1 0000a103 %h", insn_valid, latched_insn, flags, F_LOAD);
      end
      // second overlap, store word
      insn_ack = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h20C;
      tick();
      insn_ack = 1'b0; fetch_req = 1'b0;
      mem_ready = 1'b1; mem_rdata = 32'h00112023;
      tick();
      mem_ready = 1'b0;
      total++;
      if (insn_valid !== 1'b1 || latched_insn !== 32'h00112023 || flags !== F_STORE) begin
         bad++;
         $display("FAIL b2b_store: iv=%b insn=%h flags=%h, want 1 00112023 %h", insn_valid, latched_insn, flags, F_STORE);
      end
      release_hold();
   endtask

   task automatic test_misalign();
      issue(32'h102);
      total++;
      if (mem_valid !== 1'b0 || insn_valid !== 1'b1 || latched_insn !== 32'h0 || flags !== F_MIS ||
          mem_addr !== 32'h100) begin
         bad++;
         $display("FAIL misalign: mv=%b iv=%b insn=%h flags=%h addr=%h, want 0 1 0 %h 00000100",
                  mem_valid, insn_valid, latched_insn, flags, mem_addr, F_MIS);
      end
      release_hold();
   endtask

   task automatic test_decode();
      logic [31:0] words [4];
      logic [7:0]  exp   [4];
      words[0] = 32'h00000000; exp[0] = F_ILL;   // low bits 00
      words[1] = 32'h00208463; exp[1] = F_BR;    // beq
      words[2] = 32'h000000B7; exp[2] = F_NONE;  // lui: legal, no class
      words[3] = 32'h0000007F; exp[3] = F_ILL;   // unknown opcode
      for (int k = 0; k < 4; k++) begin
         issue(32'h300 + 32'(k * 4));
         mem_ready = 1'b1; mem_rdata = words[k];
         tick();
         mem_ready = 1'b0;
         total++;
         if (insn_valid !== 1'b1 || latched_insn !== words[k] || flags !== exp[k]) begin
            bad++;
            $display("FAIL decode_%0d: iv=%b insn=%h flags=%h, want 1 %h %h", k, insn_valid, latched_insn, flags, words[k], exp[k]);
         end
         release_hold();
      end
   endtask

   task automatic test_reset_mid_fetch();
      issue(32'h400);
      reset = 1'b1;
      tick();
      total++;
      if (mem_valid !== 1'b0 || insn_valid !== 1'b0 || mem_addr !== 32'h0 || latched_insn !== 32'h0 || flags !== F_NONE) begin
         bad++;
         $display("FAIL reset_mid: mv=%b iv=%b addr=%h insn=%h flags=%h, want all 0",
                  mem_valid, insn_valid, mem_addr, latched_insn, flags);
      end
      reset = 1'b0;
      mem_ready = 1'b1; mem_rdata = 32'h00B50533;
      tick(); tick();
      mem_ready = 1'b0;
      total++;
      if (insn_valid !== 1'b0 || latched_insn !== 32'h0) begin
         bad++;
         $display("FAIL stale_ready: iv=%b insn=%h, want 0 0", insn_valid, latched_insn);
      end
   endtask

   task automatic test_timeout();
      int mv_cycles = 0;
      bit done = 1'b0;
      do_reset();
      issue(32'h500);
      for (int i = 0; i < 10 && !done; i++) begin
         if (t_mem_valid === 1'b1) mv_cycles++;
         if (t_insn_valid === 1'b1) done = 1'b1;
         else tick();
      end
      total++;
      if (!done || mv_cycles != 4 || t_flags !== F_TO || t_latched_insn !== 32'h0) begin
         bad++;
         $display("FAIL timeout: done=%b mv_cycles=%0d flags=%h insn=%h, want 1 4 %h 0",
                  done, mv_cycles, t_flags, t_latched_insn, F_TO);
      end
      release_hold();
      // mem_ready arrives in the expiry cycle
      issue(32'h504);
      tick(); tick(); tick();
      mem_ready = 1'b1; mem_rdata = 32'h00A00093;
      #1;
      total++;
      if (t_mem_valid !== 1'b1 || t_insn_valid !== 1'b0) begin
         bad++;
         $display("FAIL timeout_4th: mv=%b iv=%b, want 1 0", t_mem_valid, t_insn_valid);
      end
      tick();
      mem_ready = 1'b0;
      total++;
      if (t_insn_valid !== 1'b1 || t_latched_insn !== 32'h00A00093 || t_flags !== F_I) begin
         bad++;
         $display("FAIL timeout_race: iv=%b insn=%h flags=%h, want 1 00a00093 %h", t_insn_valid, t_latched_insn, t_flags, F_I);
      end
      release_hold();
   endtask

   initial begin
      test_reset();
      test_add_min_latency();
      test_addi_wait_hold();
      test_back_to_back();
      test_misalign();
      test_decode();
      test_reset_mid_fetch();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
